// File: rtl/spi_port_arbiter.sv
// spi_port_arbiter
// Shared SPI mode-0 sequencer for the support CPLD. One SDO/SDI pair is
// time-shared between an 8-bit CPU flash channel and two 16-bit LED
// display chains, each with its own SCK line. Fixed priority
// cpu > led1 > led2. Frames are never preempted. LED frames end with a
// storage-register latch strobe.
//
// Ports:
//   clk, rst                 system clock, async active-high reset
//   cpu_req/wdata/rdata/ack  flash byte transfer (level req, 1-cycle ack)
//   led1_req/data/ack        LED chain 1 refresh (16-bit frame)
//   led2_req/data/ack        LED chain 2 refresh (16-bit frame)
//   SDO, SDI                 shared serial data pair (SDI used by cpu only)
//   SCK_FLASH/LED1/LED2      per-device serial clocks
//   LATCH1, LATCH2           LED chain latch strobes
//   gnt                      current owner: 0 none, 1 cpu, 2 led1, 3 led2
//   busy                     high whenever not IDLE
module spi_port_arbiter #(
   parameter int DIV = 2   // clk cycles per SCK half-period, 1..15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ack,
   input  logic        led1_req,
   input  logic [15:0] led1_data,
   output logic        led1_ack,
   input  logic        led2_req,
   input  logic [15:0] led2_data,
   output logic        led2_ack,
   output logic        SDO,
   input  logic        SDI,
   output logic        SCK_FLASH,
   output logic        SCK_LED1,
   output logic        SCK_LED2,
   output logic        LATCH1,
   output logic        LATCH2,
   output logic [1:0]  gnt,
   output logic        busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_LATCH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [1:0] G_NONE = 2'd0;
   localparam logic [1:0] G_CPU  = 2'd1;
   localparam logic [1:0] G_LED1 = 2'd2;
   localparam logic [1:0] G_LED2 = 2'd3;

   localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

   logic [1:0]  state_q, state_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [15:0] sh_q, sh_d;      // transmit shift register, MSB is on SDO
   logic [7:0]  rx_q, rx_d;      // receive shift register (cpu frames)
   logic [3:0]  bit_q, bit_d;    // bits remaining after the current one
   logic [3:0]  div_q, div_d;    // cycle count within a half-period
   logic        ph_q, ph_d;      // SCK phase: 0 low half, 1 high half
   logic [7:0]  rdata_q, rdata_d;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sh_d    = sh_q;
      rx_d    = rx_q;
      bit_d   = bit_q;
      div_d   = div_q;
      ph_d    = ph_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            div_d = 4'd0;
            ph_d  = 1'b0;
            if (cpu_req) begin
               gnt_d   = G_CPU;
               sh_d    = {cpu_wdata, 8'h00};
               bit_d   = 4'd7;
               rx_d    = 8'h00;
               state_d = ST_SHIFT;
            end else if (led1_req) begin
               gnt_d   = G_LED1;
               sh_d    = led1_data;
               bit_d   = 4'd15;
               state_d = ST_SHIFT;
            end else if (led2_req) begin
               gnt_d   = G_LED2;
               sh_d    = led2_data;
               bit_d   = 4'd15;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = 4'd0;
               if (!ph_q) begin
                  // SCK rising: sample SDI
                  ph_d = 1'b1;
                  if (gnt_q == G_CPU) rx_d = {rx_q[6:0], SDI};
               end else begin
                  // SCK falling: present next bit
                  ph_d = 1'b0;
                  sh_d = {sh_q[14:0], 1'b0};
                  if (bit_q == 4'd0) begin
                     if (gnt_q == G_CPU) begin
                        state_d = ST_DONE;
                        rdata_d = rx_q;
                     end else begin
                        state_d = ST_LATCH;
                     end
                  end else begin
                     bit_d = bit_q - 4'd1;
                  end
               end
            end else begin
               div_d = div_q + 4'd1;
            end
         end
         ST_LATCH: begin
            if (div_q == DIV_LAST) begin
               div_d   = 4'd0;
               state_d = ST_DONE;
            end else begin
               div_d = div_q + 4'd1;
            end
         end
         default: begin   // ST_DONE
            state_d = ST_IDLE;
            gnt_d   = G_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= G_NONE;
         sh_q    <= 16'h0000;
         rx_q    <= 8'h00;
         bit_q   <= 4'd0;
         div_q   <= 4'd0;
         ph_q    <= 1'b0;
         rdata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sh_q    <= sh_d;
         rx_q    <= rx_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         ph_q    <= ph_d;
         rdata_q <= rdata_d;
      end
   end

   // All outputs decode straight from flops, so an async reset clears them at once.
   logic sck_on;
   assign sck_on    = (state_q == ST_SHIFT) && ph_q;
   assign SCK_FLASH = sck_on && (gnt_q == G_CPU);
   assign SCK_LED1  = sck_on && (gnt_q == G_LED1);
   assign SCK_LED2  = sck_on && (gnt_q == G_LED2);
   assign LATCH1    = (state_q == ST_LATCH) && (gnt_q == G_LED1);
   assign LATCH2    = (state_q == ST_LATCH) && (gnt_q == G_LED2);
   assign cpu_ack   = (state_q == ST_DONE) && (gnt_q == G_CPU);
   assign led1_ack  = (state_q == ST_DONE) && (gnt_q == G_LED1);
   assign led2_ack  = (state_q == ST_DONE) && (gnt_q == G_LED2);
   assign SDO       = (state_q == ST_SHIFT || state_q == ST_LATCH) && sh_q[15];
   assign gnt       = gnt_q;
   assign busy      = (state_q != ST_IDLE);
   assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_spi_port_arbiter.sv
module tb_spi_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance 2: DIV=2, SDI looped back from SDO
   logic        rst2;
   logic        cpu_req2, led1_req2, led2_req2;
   logic [7:0]  cpu_wdata2;
   logic [15:0] led1_data2, led2_data2;
   logic [7:0]  rd2;
   logic        cack2, l1ack2, l2ack2, sdo2, sf2, sl12, sl22, lt12, lt22, busy2;
   logic [1:0]  gnt2;

   // instance 1: DIV=1, SDI held high
   logic        rst1;
   logic        cpu_req1, led1_req1, led2_req1;
   logic [7:0]  cpu_wdata1;
   logic [15:0] led1_data1, led2_data1;
   logic [7:0]  rd1;
   logic        cack1, l1ack1, l2ack1, sdo1, sf1, sl11, sl21, lt11, lt21, busy1;
   logic [1:0]  gnt1;

   spi_port_arbiter #(.DIV(2)) u_dut2 (
      .clk(clk), .rst(rst2),
      .cpu_req(cpu_req2), .cpu_wdata(cpu_wdata2), .cpu_rdata(rd2), .cpu_ack(cack2),
      .led1_req(led1_req2), .led1_data(led1_data2), .led1_ack(l1ack2),
      .led2_req(led2_req2), .led2_data(led2_data2), .led2_ack(l2ack2),
      .SDO(sdo2), .SDI(sdo2),
      .SCK_FLASH(sf2), .SCK_LED1(sl12), .SCK_LED2(sl22),
      .LATCH1(lt12), .LATCH2(lt22), .gnt(gnt2), .busy(busy2));

   spi_port_arbiter #(.DIV(1)) u_dut1 (
      .clk(clk), .rst(rst1),
      .cpu_req(cpu_req1), .cpu_wdata(cpu_wdata1), .cpu_rdata(rd1), .cpu_ack(cack1),
      .led1_req(led1_req1), .led1_data(led1_data1), .led1_ack(l1ack1),
      .led2_req(led2_req1), .led2_data(led2_data1), .led2_ack(l2ack1),
      .SDO(sdo1), .SDI(1'b1),
      .SCK_FLASH(sf1), .SCK_LED1(sl11), .SCK_LED2(sl21),
      .LATCH1(lt11), .LATCH2(lt21), .gnt(gnt1), .busy(busy1));

   // observation mux: use1 selects which instance the checks look at
   logic        use1;
   logic [7:0]  o_rd;
   logic        o_cack, o_l1ack, o_l2ack, o_sdo, o_sf, o_sl1, o_sl2, o_lt1, o_lt2, o_busy;
   logic [1:0]  o_gnt;
   logic [19:0] o_all;
   assign o_rd    = use1 ? rd1    : rd2;
   assign o_cack  = use1 ? cack1  : cack2;
   assign o_l1ack = use1 ? l1ack1 : l1ack2;
   assign o_l2ack = use1 ? l2ack1 : l2ack2;
   assign o_sdo   = use1 ? sdo1   : sdo2;
   assign o_sf    = use1 ? sf1    : sf2;
   assign o_sl1   = use1 ? sl11   : sl12;
   assign o_sl2   = use1 ? sl21   : sl22;
   assign o_lt1   = use1 ? lt11   : lt12;
   assign o_lt2   = use1 ? lt21   : lt22;
   assign o_busy  = use1 ? busy1  : busy2;
   assign o_gnt   = use1 ? gnt1   : gnt2;
   assign o_all   = {o_rd, o_cack, o_l1ack, o_l2ack, o_sdo, o_sf, o_sl1, o_sl2,
                     o_lt1, o_lt2, o_gnt, o_busy};

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0]  ch;
      int          ack;
      logic [15:0] word;
      int          nbits;
      logic [7:0]  rdata;
      int          lat_first;
      int          lat_n;
   } exp_t;
   exp_t sb[$];

   // results of the last observed frame
   int          r_ack, r_rises, r_other, r_lat_first, r_lat_n;
   logic [15:0] r_word;
   logic [7:0]  r_rdata;
   logic [1:0]  r_gnt0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic [1:0] ch, input logic v);
      if (use1) begin
         case (ch)
            2'd1: cpu_req1 = v;
            2'd2: led1_req1 = v;
            default: led2_req1 = v;
         endcase
      end else begin
         case (ch)
            2'd1: cpu_req2 = v;
            2'd2: led1_req2 = v;
            default: led2_req2 = v;
         endcase
      end
   endtask

   // expectations derived from the frame timing formulas
   task automatic push_exp(input logic [1:0] ch, input logic [15:0] word, input logic [7:0] rdata);
      exp_t e;
      int d;
      d = use1 ? 1 : 2;
      e.ch        = ch;
      e.word      = word;
      e.rdata     = rdata;
      e.nbits     = (ch == 2'd1) ? 8 : 16;
      e.ack       = (ch == 2'd1) ? 16 * d : 33 * d;
      e.lat_first = (ch == 2'd1) ? -1 : 32 * d;
      e.lat_n     = (ch == 2'd1) ? 0 : d;
      sb.push_back(e);
   endtask

   // First negedge inside is frame cycle 0. Drops the owner's req on its ack.
   task automatic observe(input logic [1:0] ch, input int budget, input int cpu_at, input int l2_at);
      logic prev, own, ack;
      prev = 1'b0;
      r_ack = -1; r_rises = 0; r_other = 0; r_lat_first = -1; r_lat_n = 0;
      r_word = 16'h0; r_rdata = 8'h0; r_gnt0 = 2'd0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (c == 0) r_gnt0 = o_gnt;
         if (c == cpu_at) set_req(2'd1, 1'b1);
         if (l2_at >= 0 && c == l2_at) set_req(2'd3, 1'b1);
         if (l2_at >= 0 && c == l2_at + 1) set_req(2'd3, 1'b0);
         own = (ch == 2'd1) ? o_sf : (ch == 2'd2) ? o_sl1 : o_sl2;
         if (own && !prev) begin
            r_rises++;
            r_word = {r_word[14:0], o_sdo};
         end
         prev = own;
         if ((ch != 2'd1 && o_sf) || (ch != 2'd2 && o_sl1) || (ch != 2'd3 && o_sl2)) r_other++;
         if (o_lt1 || o_lt2) begin
            if (r_lat_first < 0) r_lat_first = c;
            r_lat_n++;
         end
         ack = (ch == 2'd1) ? o_cack : (ch == 2'd2) ? o_l1ack : o_l2ack;
         if (ack) begin
            r_ack = c;
            r_rdata = o_rd;
            set_req(ch, 1'b0);
            break;
         end
      end
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      e = sb.pop_front();
      chk({tag, "_ack_cycle"}, r_ack, e.ack);
      chk({tag, "_sdo_bits"}, r_word, e.word);
      chk({tag, "_sck_pulses"}, r_rises, e.nbits);
      chk({tag, "_other_sck"}, r_other, 0);
      chk({tag, "_gnt"}, r_gnt0, e.ch);
      chk({tag, "_latch_cycles"}, r_lat_n, e.lat_n);
      if (e.ch == 2'd1) chk({tag, "_rdata"}, r_rdata, e.rdata);
      else              chk({tag, "_latch_first"}, r_lat_first, e.lat_first);
   endtask

   task automatic idle_chk(input string tag);
      @(negedge clk);
      chk({tag, "_idle_busy"}, o_busy, 0);
      chk({tag, "_idle_gnt"}, o_gnt, 0);
   endtask

   initial begin
      int n_l2ack, n_busy;
      use1 = 1'b0;
      rst1 = 1'b1; rst2 = 1'b1;
      {cpu_req1, led1_req1, led2_req1, cpu_req2, led1_req2, led2_req2} = '0;
      cpu_wdata1 = '0; led1_data1 = '0; led2_data1 = '0;
      cpu_wdata2 = '0; led1_data2 = '0; led2_data2 = '0;
      repeat (3) @(negedge clk);
      chk("reset_dut2", o_all, 0);
      use1 = 1'b1; #1;
      chk("reset_dut1", o_all, 0);
      use1 = 1'b0;
      rst1 = 1'b0; rst2 = 1'b0;
      @(negedge clk);
      chk("post_reset_idle", o_all, 0);

      // single cpu byte, loopback
      cpu_wdata2 = 8'hA5; cpu_req2 = 1'b1;
      push_exp(2'd1, 16'h00A5, 8'hA5);
      observe(2'd1, 200, -1, -1);
      sb_check("cpu_a5");
      idle_chk("cpu_a5");

      // single led1 frame
      led1_data2 = 16'h8001; led1_req2 = 1'b1;
      push_exp(2'd2, 16'h8001, 8'h00);
      observe(2'd2, 200, -1, -1);
      sb_check("led1_8001");
      idle_chk("led1_8001");

      // all three at once: served in priority order, one IDLE cycle apart
      cpu_wdata2 = 8'h5A; led1_data2 = 16'h1234; led2_data2 = 16'hBEEF;
      cpu_req2 = 1'b1; led1_req2 = 1'b1; led2_req2 = 1'b1;
      push_exp(2'd1, 16'h005A, 8'h5A);
      push_exp(2'd2, 16'h1234, 8'h00);
      push_exp(2'd3, 16'hBEEF, 8'h00);
      observe(2'd1, 200, -1, -1); sb_check("prio_cpu");  idle_chk("prio_cpu");
      observe(2'd2, 200, -1, -1); sb_check("prio_led1"); idle_chk("prio_led1");
      observe(2'd3, 200, -1, -1); sb_check("prio_led2"); idle_chk("prio_led2");

      // cpu request mid led2 frame waits for it to finish
      led2_data2 = 16'h0F0F; cpu_wdata2 = 8'hC3; led2_req2 = 1'b1;
      push_exp(2'd3, 16'h0F0F, 8'h00);
      push_exp(2'd1, 16'h00C3, 8'hC3);
      observe(2'd3, 200, 10, -1); sb_check("nopre_led2"); idle_chk("nopre_led2");
      observe(2'd1, 200, -1, -1); sb_check("nopre_cpu");  idle_chk("nopre_cpu");

      // async reset at cycle 20 of a cpu frame
      cpu_wdata2 = 8'hFF; cpu_req2 = 1'b1;
      repeat (21) @(negedge clk);
      chk("prerst_sdo", o_sdo, 1);
      chk("prerst_gnt", o_gnt, 1);
      rst2 = 1'b1; #1;
      chk("rst_async_outputs", o_all, 0);
      @(negedge clk);
      chk("rst_no_ack", o_cack, 0);
      rst2 = 1'b0;
      push_exp(2'd1, 16'h00FF, 8'hFF);
      observe(2'd1, 200, -1, -1); sb_check("after_rst"); idle_chk("after_rst");

      // DIV=1, SDI held high, short led2 pulse while busy
      use1 = 1'b1;
      cpu_wdata1 = 8'h3C; led2_data1 = 16'hFFFF; cpu_req1 = 1'b1;
      push_exp(2'd1, 16'h003C, 8'hFF);
      observe(2'd1, 100, -1, 5); sb_check("div1_cpu");
      n_l2ack = 0; n_busy = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (o_l2ack) n_l2ack++;
         if (o_busy) n_busy++;
      end
      chk("div1_no_led2_ack", n_l2ack, 0);
      chk("div1_no_led2_frame", n_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
